hdmi_pio_cfg_scheduler: RTL and testbench

- Avalon-MM slave that buffers HPS-written HDMI configuration words in a small FIFO.
- Applies them to the 32-bit HDMI control output one word per video frame, on the vsync rising edge, so settings never change mid-frame.
- Sits between the HPS lightweight bridge and the HDMI output logic, which treats out_port as a plain control register.

---
 rtl/hdmi_pio_pkg.sv | 32 +++
 rtl/hdmi_cfg_fifo.sv | 64 ++++++
 rtl/hdmi_pio_cfg_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_hdmi_pio_cfg_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pio_pkg.sv
// Shared definitions for the HDMI PIO configuration scheduler:
// Avalon register addresses, ctrl bit positions, FSM states and the
// status-word packing helper.
package hdmi_pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;
   localparam logic [1:0] ADDR_HOLD = 2'd2;
   localparam logic [1:0] ADDR_DROP = 2'd3;

   localparam int CTRL_IMM    = 0;
   localparam int CTRL_FLUSH  = 1;
   localparam int CTRL_IRQ_EN = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      APPLY = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Status word: count in 15:8, flags in 4:0, unused bits zero.
   function automatic logic [15:0] pack_status(input logic [7:0] cnt,
                                               input logic       busy,
                                               input logic       irq_en,
                                               input logic       imm,
                                               input logic       full,
                                               input logic       empty);
      pack_status = {cnt, 3'b000, busy, irq_en, imm, full, empty};
   endfunction

endpackage

// File: rtl/hdmi_cfg_fifo.sv
// Synchronous show-ahead FIFO for configuration words. The head word is
// always visible on dout; full/empty come from the registered count, so a
// push on a full FIFO is refused even when a pop happens in the same cycle.
module hdmi_cfg_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_push_ok;
   logic              w_pop_ok;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == {CW{1'b0}});
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_push_ok = push & ~full & ~flush;
   assign w_pop_ok  = pop & ~empty & ~flush;

   // Storage array: written only on an accepted push.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; flush empties the FIFO at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else if (flush) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/hdmi_pio_cfg_scheduler.sv
// HDMI PIO configuration scheduler: Avalon-MM slave that queues config
// words and applies one per video frame on the vsync rising edge.
// Optional macro HDMI_VSYNC_SYNC_EN inserts a 2-flop synchronizer on
// vsync_in (adds 2 cycles of latency, allows an asynchronous vsync).
module hdmi_pio_cfg_scheduler
   import hdmi_pio_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                FIFO_DEPTH  = 4,
   parameter logic [DATA_W-1:0] RESET_VALUE = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic              read_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   input  logic              vsync_in,
   output logic [DATA_W-1:0] out_port,
   output logic              irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t            r_state;
   logic [DATA_W-1:0] r_out;
   logic [DATA_W-1:0] r_frames;
   logic [DATA_W-1:0] r_dropped;
   logic [7:0]        r_holdoff;
   logic [7:0]        r_hold_cnt;
   logic              r_imm;
   logic              r_irq_en;
   logic              r_irq;
   logic              r_vsync_q;

   logic              w_wr, w_push, w_ctrl_wr, w_flush, w_pop;
   logic              w_vs, w_vs_rise, w_full, w_empty, w_irq_next;
   logic [DATA_W-1:0] w_dout;
   logic [CW-1:0]     w_count;
   logic              w_unused_read;

   // readdata is a pure address mux, so the read strobe carries no state.
   assign w_unused_read = read_n;

   assign w_wr      = chipselect & ~write_n;
   assign w_push    = w_wr & (address == ADDR_DATA);
   assign w_ctrl_wr = w_wr & (address == ADDR_CTRL);
   assign w_flush   = w_ctrl_wr & writedata[CTRL_FLUSH];
   assign w_pop     = (r_state == APPLY) & ~w_flush;

`ifdef HDMI_VSYNC_SYNC_EN
   logic r_vs_meta;
   logic r_vs_sync;

   // Two-flop synchronizer for an asynchronous vsync.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vs_meta <= 1'b0;
         r_vs_sync <= 1'b0;
      end else begin
         r_vs_meta <= vsync_in;
         r_vs_sync <= r_vs_meta;
      end
   end
   assign w_vs = r_vs_sync;
`else
   assign w_vs = vsync_in;
`endif

   assign w_vs_rise = w_vs & ~r_vsync_q;

   hdmi_cfg_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (w_flush),
      .din     (writedata),
      .dout    (w_dout),
      .count   (w_count),
      .full    (w_full),
      .empty   (w_empty)
   );

   // Previous vsync level for rising-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_vsync_q <= 1'b0;
      else          r_vsync_q <= w_vs;
   end

   // Apply scheduler: owns the state, the applied word, frame and hold counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_out      <= RESET_VALUE;
         r_frames   <= {DATA_W{1'b0}};
         r_hold_cnt <= 8'd0;
      end else if (w_flush) begin
         r_state    <= IDLE;
         r_hold_cnt <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_count != {CW{1'b0}}) r_state <= ARMED;
            end
            ARMED: begin
               if (r_imm | w_vs_rise) r_state <= APPLY;
            end
            APPLY: begin
               r_out    <= w_dout;
               r_frames <= r_frames + DATA_W'(1);
               if ((r_holdoff != 8'd0) && !r_imm) begin
                  r_state    <= HOLD;
                  r_hold_cnt <= r_holdoff;
               end else if (w_count > CW'(1)) begin
                  r_state <= ARMED;
               end else begin
                  r_state <= IDLE;
               end
            end
            HOLD: begin
               if (w_vs_rise) begin
                  if (r_hold_cnt <= 8'd1) begin
                     r_hold_cnt <= 8'd0;
                     r_state    <= (w_count != {CW{1'b0}}) ? ARMED : IDLE;
                  end else begin
                     r_hold_cnt <= r_hold_cnt - 8'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Control and holdoff registers written over Avalon.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_imm     <= 1'b0;
         r_irq_en  <= 1'b0;
         r_holdoff <= 8'd0;
      end else begin
         if (w_ctrl_wr) begin
            r_imm    <= writedata[CTRL_IMM];
            r_irq_en <= writedata[CTRL_IRQ_EN];
         end
         if (w_wr && (address == ADDR_HOLD)) r_holdoff <= writedata[7:0];
      end
   end

   // Dropped-push counter: saturates, cleared by a write to its address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dropped <= {DATA_W{1'b0}};
      end else if (w_wr && (address == ADDR_DROP)) begin
         r_dropped <= {DATA_W{1'b0}};
      end else if (w_push && w_full && (r_dropped != {DATA_W{1'b1}})) begin
         r_dropped <= r_dropped + DATA_W'(1);
      end
   end

   // A push or a write clearing irq_en suppresses the interrupt right away.
   assign w_irq_next = r_irq_en & w_empty & (r_frames != {DATA_W{1'b0}}) & ~w_push
                       & ~(w_ctrl_wr & ~writedata[CTRL_IRQ_EN]);

   // Registered level interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_irq <= 1'b0;
      else          r_irq <= w_irq_next;
   end

   // Combinational register read mux.
   always_comb begin
      readdata = {DATA_W{1'b0}};
      case (address)
         ADDR_DATA: readdata = r_out;
         ADDR_CTRL: readdata = {{(DATA_W-16){1'b0}},
                                pack_status(8'(w_count), (r_state != IDLE), r_irq_en,
                                            r_imm, w_full, w_empty)};
         ADDR_HOLD: readdata = r_frames;
         ADDR_DROP: readdata = r_dropped;
         default:   readdata = {DATA_W{1'b0}};
      endcase
   end

   assign out_port = r_out;
   assign irq      = r_irq;

endmodule

// File: tb/tb_hdmi_pio_cfg_scheduler.sv
// Self-checking bench for hdmi_pio_cfg_scheduler: directed scenarios and a
// randomized phase, all compared every cycle against a queue-based model.
module tb_hdmi_pio_cfg_scheduler;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'hC0DE_0001;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic        read_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        vsync_in = 1'b0;
   logic [31:0] out_port;
   logic        irq;

   hdmi_pio_cfg_scheduler #(.DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
      .vsync_in(vsync_in), .out_port(out_port), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_q[$];
   logic [31:0] m_out, m_frames, m_drop;
   bit          m_irq, m_imm, m_irq_en, m_armed, m_applying;
   int          m_hold, m_skip;
   bit          m_vs_prev, m_vs_d1, m_vs_d2;

   task automatic m_reset();
      m_q.delete();
      m_out = RV; m_frames = 0; m_drop = 0;
      m_irq = 0; m_imm = 0; m_irq_en = 0; m_armed = 0; m_applying = 0;
      m_hold = 0; m_skip = 0; m_vs_prev = 0; m_vs_d1 = 0; m_vs_d2 = 0;
   endtask

   function automatic logic [31:0] m_rd(input logic [1:0] a);
      int sz;
      bit busy;
      sz = m_q.size();
      busy = m_armed || m_applying || (m_skip > 0);
      case (a)
         2'd0: return m_out;
         2'd1: return (32'(sz) << 8) | (32'(busy) << 4) | (32'(m_irq_en) << 3) |
                      (32'(m_imm) << 2) | (32'(sz == DEPTH) << 1) | 32'(sz == 0);
         2'd2: return m_frames;
         default: return m_drop;
      endcase
   endfunction

   task automatic m_step(input bit cs, input bit wn, input logic [1:0] a,
                         input logic [31:0] d, input bit vs);
      bit wr, push, ctrlw, flush, vs_eff, rise, n_irq, popnow;
      int cnt;
      wr = cs && !wn;
      push = wr && (a == 2'd0);
      ctrlw = wr && (a == 2'd1);
      flush = ctrlw && d[1];
      cnt = m_q.size();
`ifdef HDMI_VSYNC_SYNC_EN
      vs_eff = m_vs_d2; m_vs_d2 = m_vs_d1; m_vs_d1 = vs;
`else
      vs_eff = vs;
`endif
      rise = vs_eff && !m_vs_prev;
      m_vs_prev = vs_eff;
      n_irq = m_irq_en && (cnt == 0) && (m_frames != 0) && !push && !(ctrlw && !d[2]);
      if (wr && a == 2'd3) m_drop = 0;
      else if (push && cnt == DEPTH && m_drop != 32'hFFFF_FFFF) m_drop++;
      if (flush) begin
         m_armed = 0; m_applying = 0; m_skip = 0; m_q.delete();
      end else begin
         popnow = m_applying;
         if (m_applying) begin
            m_out = m_q[0]; m_frames++; m_applying = 0;
            if (m_hold != 0 && !m_imm) m_skip = m_hold;
            else m_armed = (cnt > 1);
         end else if (m_skip > 0) begin
            if (rise) begin
               m_skip--;
               if (m_skip == 0) m_armed = (cnt != 0);
            end
         end else if (m_armed) begin
            if (m_imm || rise) begin m_applying = 1; m_armed = 0; end
         end else begin
            m_armed = (cnt != 0);
         end
         if (popnow) void'(m_q.pop_front());
         if (push && cnt < DEPTH) m_q.push_back(d);
      end
      if (ctrlw) begin m_imm = d[0]; m_irq_en = d[2]; end
      if (wr && a == 2'd2) m_hold = int'(d[7:0]);
      m_irq = n_irq;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input bit cs, input bit wn, input logic [1:0] a,
                      input logic [31:0] d, input bit vs);
      chipselect = cs; write_n = wn; read_n = ~(cs & wn);
      address = a; writedata = d; vsync_in = vs;
      @(negedge clk);
      chk("out_port", out_port, m_out);
      chk("irq", 32'(irq), 32'(m_irq));
      chk("readdata", readdata, m_rd(a));
      last_rd = readdata;
      @(posedge clk);
      m_step(cs, wn, a, d, vs);
      #1;
   endtask

   task automatic push_w(input logic [31:0] d); cyc(1, 0, 2'd0, d, 0); endtask
   task automatic wctrl(input logic [31:0] d); cyc(1, 0, 2'd1, d, 0); endtask
   task automatic rd(input logic [1:0] a);      cyc(0, 1, a, 32'd0, 0); endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 1, 2'd0, 32'd0, 0);
   endtask
   task automatic pulse();
      cyc(0, 1, 2'd0, 32'd0, 1);
      idle(5);
   endtask

   logic [31:0] words[5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

   initial begin
      bit vs_lvl, cs, wn, seen;
      logic [1:0] a;
      logic [31:0] d;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // reset state
      rd(2'd1);
      chk("rst_status", last_rd, 32'h1);
      chk("rst_out", out_port, RV);
      chk("rst_irq", 32'(irq), 32'd0);

      // basic two-frame apply
      push_w(32'hA5); push_w(32'h5A); idle(3);
      pulse(); chk("apply1", out_port, 32'hA5);
      pulse(); chk("apply2", out_port, 32'h5A);
      rd(2'd2); chk("frames2", last_rd, 32'd2);

      // overflow, dropped count, irq
      wctrl(32'h4);
      for (int i = 0; i < 5; i++) push_w(words[i]);
      idle(2);
      rd(2'd1); chk("full_bit", last_rd & 32'h2, 32'h2);
      chk("full_count", (last_rd >> 8) & 32'hFF, 32'd4);
      rd(2'd3); chk("dropped1", last_rd, 32'd1);
      for (int i = 0; i < 4; i++) begin
         pulse(); chk("ovf_apply", out_port, words[i]);
      end
      idle(2); chk("irq_set", 32'(irq), 32'd1);
      cyc(1, 0, 2'd3, 32'd0, 0); rd(2'd3); chk("drop_clr", last_rd, 32'd0);

      // holdoff = 2: applies on edges 1, 4, 7
      cyc(1, 0, 2'd2, 32'd2, 0); wctrl(32'h0);
      push_w(32'h61); push_w(32'h62); push_w(32'h63); idle(3);
      for (int e = 1; e <= 7; e++) begin
         pulse();
         chk("holdoff", out_port, (e < 4) ? 32'h61 : ((e < 7) ? 32'h62 : 32'h63));
      end
      pulse(); pulse();
      cyc(1, 0, 2'd2, 32'd0, 0);

      // immediate mode
      wctrl(32'h1);
      push_w(32'h71); push_w(32'h72); push_w(32'h73);
      idle(8); chk("imm_last", out_port, 32'h73);
      wctrl(32'h0);

      // flush keeps out_port, FIFO empties, FSM idles
      push_w(32'h81); push_w(32'h82); wctrl(32'h2);
      rd(2'd1); chk("flush_status", last_rd, 32'h1);
      pulse(); pulse(); chk("flush_out", out_port, 32'h73);
      push_w(32'h81); wctrl(32'h2); push_w(32'h91);
      rd(2'd1); chk("post_flush_cnt", (last_rd >> 8) & 32'hFF, 32'd1);
      idle(2); pulse(); chk("post_flush_apply", out_port, 32'h91);

      // reset asserted while in APPLY
      push_w(32'hA1); idle(3); cyc(0, 1, 2'd0, 32'd0, 1);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (m_applying) seen = 1;
         else idle(1);
      end
      chk("apply_reached", 32'(seen), 32'd1);
      #2 reset_n = 1'b0;
      m_reset();
      #1 chk("rst_apply_out", out_port, RV);
      chk("rst_apply_irq", 32'(irq), 32'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      rd(2'd1); chk("rst_apply_status", last_rd, 32'h1);
      idle(4); chk("rst_apply_hold", out_port, RV);

      // randomized traffic
      vs_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         cs = ($urandom_range(0, 7) != 0);
         wn = ($urandom_range(0, 2) != 0);
         a  = 2'($urandom_range(0, 3));
         d  = $urandom;
         if (a == 2'd1)
            d = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 3) == 0)};
         else if (a == 2'd2)
            d = 32'($urandom_range(0, 3));
         else if (a == 2'd3 && $urandom_range(0, 3) != 0)
            wn = 1;
         if ($urandom_range(0, 5) == 0) vs_lvl = ~vs_lvl;
         cyc(cs, wn, a, d, vs_lvl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
